// File: rtl/epidemic_monitor.sv
// Observes an agent-infection network run by run: counts infected agents each step,
// tracks the peak, detects termination and offers change records through a one-deep buffer.
module epidemic_monitor #(
  parameter int N_AGENTS     = 10,
  parameter int STABLE_LIMIT = 3,
  parameter int MAX_STEPS    = 255,
  localparam int CW          = $clog2(N_AGENTS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_AGENTS-1:0] states,
  output logic                load_state,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [7:0]          rec_step,
  output logic [CW-1:0]       rec_count,
  output logic [CW-1:0]       peak_count,
  output logic [7:0]          peak_step,
  output logic                done,
  output logic [1:0]          reason,
  output logic                overflow
);

  localparam int SW = $clog2(STABLE_LIMIT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]          fsm;
  logic [7:0]          step;
  logic [N_AGENTS-1:0] prev_states;
  logic [CW-1:0]       prev_count;
  logic [SW-1:0]       stable_cnt;

  logic [CW-1:0]       count;
  logic                new_rec;
  logic [SW-1:0]       stable_next;
  logic [1:0]          term_reason;

  assign load_state = (fsm == LOAD);
  assign done       = (fsm == DONE);

  // Population count, stable-run tracking and prioritised termination for the current step.
  always_comb begin
    count = '0;
    for (int i = 0; i < N_AGENTS; i++) begin
      count = count + CW'(states[i]);
    end
    new_rec = (step == 8'd0) || (count != prev_count);
    stable_next = '0;
    if (step != 8'd0 && states == prev_states) begin
      stable_next = (stable_cnt == SW'(STABLE_LIMIT)) ? stable_cnt : stable_cnt + SW'(1);
    end
    term_reason = 2'b00;
    if (count == CW'(N_AGENTS)) begin
      term_reason = 2'b01;
    end else if (stable_next == SW'(STABLE_LIMIT)) begin
      term_reason = 2'b10;
    end else if (step == 8'(MAX_STEPS)) begin
      term_reason = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      step        <= '0;
      prev_states <= '0;
      prev_count  <= '0;
      stable_cnt  <= '0;
      peak_count  <= '0;
      peak_step   <= '0;
      reason      <= 2'b00;
    end else begin
      case (fsm)
        IDLE: if (start) fsm <= LOAD;
        LOAD: begin
          fsm         <= RUN;
          step        <= '0;
          prev_states <= '0;
          prev_count  <= '0;
          stable_cnt  <= '0;
          peak_count  <= '0;
          peak_step   <= '0;
          reason      <= 2'b00;
        end
        RUN: begin
          step        <= step + 8'd1;
          prev_states <= states;
          prev_count  <= count;
          stable_cnt  <= stable_next;
          // Strictly greater keeps the earliest step on ties.
          if (count > peak_count) begin
            peak_count <= count;
            peak_step  <= step;
          end
          if (term_reason != 2'b00) begin
            reason <= term_reason;
            fsm    <= DONE;
          end
        end
        default: if (start) fsm <= LOAD;
      endcase
    end
  end

  // One-deep record buffer; a new record while the old one is stuck is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_valid <= 1'b0;
      rec_step  <= '0;
      rec_count <= '0;
      overflow  <= 1'b0;
    end else if (fsm == LOAD) begin
      rec_valid <= 1'b0;
      rec_step  <= '0;
      rec_count <= '0;
      overflow  <= 1'b0;
    end else if (fsm == RUN && new_rec) begin
      if (!rec_valid || rec_ready) begin
        rec_valid <= 1'b1;
        rec_step  <= step;
        rec_count <= count;
      end else begin
        overflow <= 1'b1;
      end
    end else if (rec_valid && rec_ready) begin
      rec_valid <= 1'b0;
    end
  end

endmodule

// File: doc/epidemic_monitor.md
EPIDEMIC_MONITOR -- requirements
Module: epidemic_monitor

Interface
REQ-001 Parameter N_AGENTS, default 10: number of agents in the observed network; the width of states.
REQ-002 Parameter STABLE_LIMIT, default 3: consecutive unchanged cycles that declare a stable outbreak.
REQ-003 Parameter MAX_STEPS, default 255: step budget; the step counter is 8 bits wide.
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle pulse that launches a run; ignored in LOAD and RUN.
REQ-007 states  input  N_AGENTS  per-agent infection state from the network, bit i = agent i, 1 = infected.
REQ-008 load_state  output  1  one-cycle pulse to the network that loads its initial-state vector.
REQ-009 rec_valid / rec_ready  output / input  1 / 1  record handshake; a transfer occurs when both are high on a rising edge.
REQ-010 rec_step  output  8  step index of the pending record.
REQ-011 rec_count  output  CW  infected count of the pending record, where CW = clog2(N_AGENTS+1) (4 for the default).
REQ-012 peak_count / peak_step  output  CW / 8  highest infected count seen in the run, and the first step at which it occurred.
REQ-013 done  output  1  high while the FSM is in DONE.
REQ-014 reason  output  2  termination cause: 01 all infected, 10 stable, 11 step budget exhausted, 00 while not in DONE.
REQ-015 overflow  output  1  sticky flag set when a record is dropped.

Function
REQ-016 FSM states and transitions:
- IDLE -> LOAD on start.
- LOAD -> RUN unconditionally after one cycle.
- RUN -> DONE on a termination condition.
- DONE -> LOAD on start.
REQ-017 load_state is high only during the single LOAD cycle.
REQ-018 Entering LOAD clears the following: step, peak_count, peak_step, the stable counter, overflow and reason.
REQ-019 The first RUN cycle is step 0; states in that cycle is the loaded initial vector.
REQ-020 step increments by 1 on every RUN cycle.
REQ-021 Infected count = population count of states, computed combinationally and registered with the step at each RUN edge; record latency = 1 cycle.
REQ-022 A record is generated at step 0 and at every later step whose count differs from the previous step's count.
REQ-023 Record buffer rules:
- The block holds one record buffer.
- rec_valid stays high with rec_step and rec_count stable until the record is accepted.
- If a new record is generated while the buffer is still full and not being accepted that edge, the new record is dropped and overflow is set.
- Acceptance and a new record on the same edge: the buffer reloads with the new record and rec_valid stays high.
REQ-024 peak_count and peak_step update only when the count is strictly greater than peak_count, so ties keep the earlier step.
REQ-025 Stable counter rules:
- Increments on each RUN cycle at step >= 1 in which states equals the previous cycle's states.
- Clears to 0 on any difference.
- Saturates at STABLE_LIMIT.
REQ-026 Termination conditions are evaluated in each RUN cycle with this priority:
- count == N_AGENTS gives reason 01.
- stable counter reaching STABLE_LIMIT gives reason 10.
- step == MAX_STEPS gives reason 11.
The FSM enters DONE on the following edge.
REQ-027 Record handling across run boundaries:
- The record of the terminating step is still generated.
- A pending record remains offered in DONE until accepted.
- A start in DONE flushes the buffer (rec_valid = 0) in LOAD.
REQ-028 The states input is ignored outside RUN.

Reset
REQ-029 Asserting rst_n low, at any time including mid-run, immediately sets the FSM to IDLE and drives every output to 0: load_state, rec_valid, rec_step, rec_count, peak_count, peak_step, done, reason, overflow.
REQ-030 After rst_n deasserts, the block stays in IDLE until the first start pulse.

Verification
REQ-031 Reset, then a start pulse -> load_state is high exactly 1 cycle later, and RUN begins on the next cycle with rec_step 0.
REQ-032 states sequence 0x001, 0x003, 0x007 ... 0x3FF, rec_ready held high -> 10 records with counts 1..10 at steps 0..9, done with reason 01, peak_count 10, peak_step 9.
REQ-033 states held at 0x005 from step 0 -> one record (count 2), then reason 10 at step 3.
REQ-034 rec_ready held low, counts changing every step -> first record held, overflow = 1, later records dropped; release rec_ready -> the step-0 record transfers.
REQ-035 states oscillating between 0x001 and 0x002 with MAX_STEPS = 8 -> reason 11 at step 8, and peak_step stays 0 on the count ties.
REQ-036 rst_n pulsed low at step 4 of a run -> all outputs are 0 in the same cycle, and no load_state occurs until the next start.
